branch_unit: RTL and testbench

Branch-condition resolver for the simplerv RV32I core, sitting between the ALU comparator and the PC-select logic. It decodes the B-type funct3 field against precomputed comparison flags and produces a combinational branch-taken decision. It also flags reserved funct3 encodings and provides a registered copy of the decision plus saturating taken / not-taken statistics counters.

---
 rtl/branch_unit_pkg.sv | 19 +
 rtl/branch_unit_sat_counter.sv | 32 +++
 rtl/branch_unit.sv | 75 +++++++
 tb/tb_branch_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/branch_unit_pkg.sv
// Core-wide B-type decode constants shared by the branch resolver and PC-select logic.
// Holds funct3 encodings plus a reserved-encoding helper.
package branch_unit_pkg;

    typedef logic [2:0] funct3_t;

    localparam funct3_t F3_BEQ  = 3'b000;
    localparam funct3_t F3_BNE  = 3'b001;
    localparam funct3_t F3_BLT  = 3'b100;
    localparam funct3_t F3_BGE  = 3'b101;
    localparam funct3_t F3_BLTU = 3'b110;
    localparam funct3_t F3_BGEU = 3'b111;

    // 010 and 011 are the only B-type funct3 values RV32I leaves unassigned.
    function automatic logic is_reserved_f3(input funct3_t f3);
        return (f3[2:1] == 2'b01);
    endfunction

endpackage : branch_unit_pkg

// File: rtl/branch_unit_sat_counter.sv
// Saturating up-counter: sticks at all-ones, synchronous active-high clear.
// One-cycle latency from inc to cnt; no backpressure, inc is sampled every edge.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule : sat_counter

// File: rtl/branch_unit.sv
// Resolves B-type branch direction from funct3 and comparator flags (0-cycle taken/illegal);
// registered copies and taken/not-taken statistics update 1 cycle after br_valid, no backpressure.
module branch_unit
    import branch_unit_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       funct3,
    input  logic             eq,
    input  logic             ge,
    input  logic             less,
    input  logic             ge_u,
    input  logic             less_u,
    input  logic             br_valid,
    output logic             taken,
    output logic             illegal,
    output logic             taken_q,
    output logic             illegal_q,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] not_taken_cnt
);

    logic taken_d;
    logic illegal_d;
    logic tk_inc;
    logic nt_inc;

    // Mux form: only the selected flag reaches taken, so unused flags may float.
    always_comb begin
        taken_d = 1'b0;
        case (funct3)
            F3_BEQ:  taken_d = eq;
            F3_BNE:  taken_d = ~eq;
            F3_BLT:  taken_d = less;
            F3_BGE:  taken_d = ge;
            F3_BLTU: taken_d = less_u;
            F3_BGEU: taken_d = ge_u;
            default: taken_d = 1'b0;
        endcase
    end

    assign illegal_d = is_reserved_f3(funct3);
    assign taken     = taken_d;
    assign illegal   = illegal_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else if (br_valid) begin
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
        end
    end

    assign tk_inc = br_valid & taken_d;
    assign nt_inc = br_valid & ~taken_d & ~illegal_d;

    sat_counter #(.W(CNT_W)) u_taken_cnt (
        .clk (clk),
        .rst (rst),
        .inc (tk_inc),
        .cnt (taken_cnt)
    );

    sat_counter #(.W(CNT_W)) u_not_taken_cnt (
        .clk (clk),
        .rst (rst),
        .inc (nt_inc),
        .cnt (not_taken_cnt)
    );

endmodule : branch_unit

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: stimulus pushes expected outputs, a monitor pops and compares.
module tb_branch_unit;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       funct3;
    logic             eq, ge, less, ge_u, less_u;
    logic             br_valid;
    logic             taken, illegal, taken_q, illegal_q;
    logic [CNT_W-1:0] taken_cnt, not_taken_cnt;

    branch_unit #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .funct3        (funct3),
        .eq            (eq),
        .ge            (ge),
        .less          (less),
        .ge_u          (ge_u),
        .less_u        (less_u),
        .br_valid      (br_valid),
        .taken         (taken),
        .illegal       (illegal),
        .taken_q       (taken_q),
        .illegal_q     (illegal_q),
        .taken_cnt     (taken_cnt),
        .not_taken_cnt (not_taken_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string nm;
        logic  tk;
        logic  il;
        logic  tq;
        logic  iq;
        int    tc;
        int    nc;
    } exp_t;

    exp_t sbq[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference state, kept as plain integers and bits.
    int   m_tc = 0;
    int   m_nc = 0;
    logic m_tq = 1'b0;
    logic m_iq = 1'b0;

    // Branch semantics by mnemonic: which comparison decides the branch.
    function automatic logic ref_taken(input int f, input logic e, input logic g,
                                       input logic l, input logic gu, input logic lu);
        if (f == 0) return e;        // BEQ
        if (f == 1) return !e;       // BNE
        if (f == 4) return l;        // BLT
        if (f == 5) return g;        // BGE
        if (f == 6) return lu;       // BLTU
        if (f == 7) return gu;       // BGEU
        return 1'b0;
    endfunction

    function automatic logic ref_illegal(input int f);
        return (f == 2) || (f == 3);
    endfunction

    task automatic chk(input string nm, input string fld, input int act, input int exp);
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s.%s got %0d expected %0d", nm, fld, act, exp);
        end
    endtask

    // Monitor: outputs of the cycle are stable by the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                vectors++;
                chk(e.nm, "taken",         int'(taken),         int'(e.tk));
                chk(e.nm, "illegal",       int'(illegal),       int'(e.il));
                chk(e.nm, "taken_q",       int'(taken_q),       int'(e.tq));
                chk(e.nm, "illegal_q",     int'(illegal_q),     int'(e.iq));
                chk(e.nm, "taken_cnt",     int'(taken_cnt),     e.tc);
                chk(e.nm, "not_taken_cnt", int'(not_taken_cnt), e.nc);
            end
        end
    end

    // One cycle of stimulus: drive, record expectation, then advance the model for the next edge.
    task automatic drive(input string nm, input int f, input logic e, input logic g,
                         input logic l, input logic gu, input logic lu,
                         input logic vld, input logic r);
        exp_t x;
        logic t;
        logic il;
        @(posedge clk);
        #1;
        funct3   = 3'(f);
        eq       = e;
        ge       = g;
        less     = l;
        ge_u     = gu;
        less_u   = lu;
        br_valid = vld;
        rst      = r;
        t  = ref_taken(f, e, g, l, gu, lu);
        il = ref_illegal(f);
        x.nm = nm; x.tk = t; x.il = il;
        x.tq = m_tq; x.iq = m_iq; x.tc = m_tc; x.nc = m_nc;
        sbq.push_back(x);
        if (r) begin
            m_tq = 1'b0; m_iq = 1'b0; m_tc = 0; m_nc = 0;
        end else if (vld) begin
            m_tq = t;
            m_iq = il;
            if (t && m_tc < CNT_MAX) m_tc++;
            if (!t && !il && m_nc < CNT_MAX) m_nc++;
        end
    endtask

    // Only the flag named by funct3 is driven; the others float.
    task automatic drive_sel(input string nm, input int f, input logic v,
                             input logic vld);
        logic e, g, l, gu, lu;
        e = 1'bx; g = 1'bx; l = 1'bx; gu = 1'bx; lu = 1'bx;
        case (f)
            0, 1: e = v;
            4:    l = v;
            5:    g = v;
            6:    lu = v;
            7:    gu = v;
            default: ;
        endcase
        drive(nm, f, e, g, l, gu, lu, vld, 1'b0);
    endtask

    initial begin
        int codes[6] = '{0, 1, 4, 5, 6, 7};
        int guard;
        rst = 1'b1; br_valid = 1'b0; funct3 = 3'b000;
        eq = 1'b0; ge = 1'b0; less = 1'b0; ge_u = 1'b0; less_u = 1'b0;
        repeat (2) @(posedge clk);

        drive("reset_state", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        foreach (codes[i]) drive_sel($sformatf("taken_f%0d", codes[i]), codes[i],
                                     (codes[i] == 1) ? 1'b0 : 1'b1, 1'b0);
        foreach (codes[i]) drive_sel($sformatf("nottaken_f%0d", codes[i]), codes[i],
                                     (codes[i] == 1) ? 1'b1 : 1'b0, 1'b0);
        drive("reserved_f2", 2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drive("reserved_f3", 3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        drive("rst_pulse",   0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive("beq_valid",   0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive("hold",        3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            drive($sformatf("taken_sat%0d", i), 4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        drive_sel("nt_valid0", 5, 1'b0, 1'b1);
        drive_sel("nt_valid1", 6, 1'b0, 1'b1);
        drive("illegal_valid", 2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        drive("after_illegal", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive("rst_vs_valid",  0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        drive("after_rst",     0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            drive($sformatf("rand%0d", i), int'($urandom_range(0, 7)),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
        end
        drive("final", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        guard = 0;
        while (sbq.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (sbq.size() > 0) begin
            miscompares++;
            $display("FAIL drain queue_left %0d expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_branch_unit
